// File: rtl/ysyx_24090003_regfile_sb.sv
// GPR file with combinational read ports, optional writeback bypass and a per-register busy scoreboard.
// Zero-latency reads; issue stalls (o_iss_ready low) on a WAW hazard unless a same-cycle writeback releases it.
module ysyx_24090003_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rs_data,
  output logic [NUM_RD-1:0]          o_rs_busy,
  input  logic                       i_iss_valid,
  input  logic [ADDR_W-1:0]          i_iss_rd,
  output logic                       o_iss_ready,
  input  logic                       i_wb_valid,
  input  logic [ADDR_W-1:0]          i_wb_rd,
  input  logic [DATA_W-1:0]          i_wb_data,
  output logic                       o_init_done,
  output logic [(1<<ADDR_W)-1:0]     o_busy_vec
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;

  logic            w_run;
  logic            w_iss_acc;
  logic            w_wb_we;
  logic [NREG-1:0] w_busy_nxt;

  assign w_run       = (r_state == S_RUN);
  assign o_init_done = w_run;
  assign o_busy_vec  = r_busy;

  // A writeback to the stalled destination frees it in the same cycle.
  assign o_iss_ready = w_run & ((i_iss_rd == '0) | ~r_busy[i_iss_rd] |
                                (i_wb_valid & (i_wb_rd == i_iss_rd)));
  assign w_iss_acc   = i_iss_valid & o_iss_ready & (i_iss_rd != '0);
  assign w_wb_we     = w_run & i_wb_valid & (i_wb_rd != '0);

  // Issue is applied after writeback so a same-cycle pair leaves the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_we)   w_busy_nxt[i_wb_rd]  = 1'b0;
    if (w_iss_acc) w_busy_nxt[i_iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_busy  <= '0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + ONE_IDX;
      if (r_cnt == LAST_IDX) r_state <= S_RUN;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_INIT)
        r_regs[r_cnt] <= '0;
      else if (w_wb_we)
        r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_byp;
    assign w_addr = i_rs_addr[k*ADDR_W +: ADDR_W];
    assign w_byp  = (BYPASS != 0) && i_wb_valid && (i_wb_rd == w_addr);
    assign o_rs_data[k*DATA_W +: DATA_W] =
      (!w_run || (w_addr == '0)) ? '0 : (w_byp ? i_wb_data : r_regs[w_addr]);
    assign o_rs_busy[k] = w_run && (w_addr != '0) && !w_byp && r_busy[w_addr];
  end

endmodule

// File: tb/tb_ysyx_24090003_regfile_sb.sv
// Directed bench for ysyx_24090003_regfile_sb: bypassing, non-bypassing and RV32E (3-port) instances.
module tb_ysyx_24090003_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the two ADDR_W=5 instances
  logic [9:0]  rs_addr;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [63:0] b1_rs_data, b0_rs_data;
  logic [1:0]  b1_rs_busy, b0_rs_busy;
  logic        b1_ready, b0_ready, b1_done, b0_done;
  logic [31:0] b1_busy_vec, b0_busy_vec;

  logic [11:0] e_rs_addr;
  logic        e_iss_valid, e_wb_valid;
  logic [3:0]  e_iss_rd, e_wb_rd;
  logic [31:0] e_wb_data;
  logic [95:0] e_rs_data;
  logic [2:0]  e_rs_busy;
  logic        e_ready, e_done;
  logic [15:0] e_busy_vec;

  int n_chk = 0;
  int n_err = 0;

  ysyx_24090003_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_b1 (
    .i_clk(clk), .i_rst(rst), .i_rs_addr(rs_addr), .o_rs_data(b1_rs_data),
    .o_rs_busy(b1_rs_busy), .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
    .o_iss_ready(b1_ready), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .o_init_done(b1_done), .o_busy_vec(b1_busy_vec));

  ysyx_24090003_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_b0 (
    .i_clk(clk), .i_rst(rst), .i_rs_addr(rs_addr), .o_rs_data(b0_rs_data),
    .o_rs_busy(b0_rs_busy), .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
    .o_iss_ready(b0_ready), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .o_init_done(b0_done), .o_busy_vec(b0_busy_vec));

  ysyx_24090003_regfile_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .BYPASS(1)) u_e (
    .i_clk(clk), .i_rst(rst), .i_rs_addr(e_rs_addr), .o_rs_data(e_rs_data),
    .o_rs_busy(e_rs_busy), .i_iss_valid(e_iss_valid), .i_iss_rd(e_iss_rd),
    .o_iss_ready(e_ready), .i_wb_valid(e_wb_valid), .i_wb_rd(e_wb_rd),
    .i_wb_data(e_wb_data), .o_init_done(e_done), .o_busy_vec(e_busy_vec));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; return at posedge+1 so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_main();
    iss_valid = 1'b0; iss_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr = {a1, a0};
  endtask

  // Release reset and walk the clear sequence, checking done timing and INIT quiescence.
  task automatic run_init(input string tag);
    for (int i = 0; i < 32; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(i);
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'hFFFF_FFFF;
      set_rs(5'(i), 5'(31 - i));
      settle();
      chk({tag, "_done"}, 64'(b1_done), 64'd0);
      chk({tag, "_ready"}, 64'(b1_ready), 64'd0);
      chk({tag, "_rsdat"}, b1_rs_data, 64'd0);
      chk({tag, "_rsbusy"}, 64'(b1_rs_busy), 64'd0);
      chk({tag, "_e_done"}, 64'(e_done), (i >= 16) ? 64'd1 : 64'd0);
      tick();
    end
    idle_main();
    settle();
    chk({tag, "_done_end"}, 64'(b1_done), 64'd1);
    chk({tag, "_b0_done_end"}, 64'(b0_done), 64'd1);
    chk({tag, "_busyvec"}, 64'(b1_busy_vec), 64'd0);
    chk({tag, "_ready_end"}, 64'(b1_ready), 64'd1);
    for (int r = 0; r < 32; r += 2) begin
      set_rs(5'(r), 5'(r + 1));
      settle();
      chk({tag, "_clr"}, b1_rs_data, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_main();
    rs_addr = '0;
    e_rs_addr = '0; e_iss_valid = 1'b0; e_iss_rd = '0;
    e_wb_valid = 1'b0; e_wb_rd = '0; e_wb_data = '0;
    repeat (3) tick();
    chk("rst_done", 64'(b1_done), 64'd0);
    chk("rst_ready", 64'(b1_ready), 64'd0);
    chk("rst_busyvec", 64'(b1_busy_vec), 64'd0);
    rst = 1'b0;
    run_init("init");

    // Plain writeback; bypass instance forwards, the other shows the old value
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    set_rs(5'd5, 5'd0);
    settle();
    chk("wb5_byp", b1_rs_data, 64'h0000_0000_DEAD_BEEF);
    chk("wb5_nobyp", b0_rs_data, 64'd0);
    tick();
    idle_main();
    settle();
    chk("rd5_b1", b1_rs_data, 64'h0000_0000_DEAD_BEEF);
    chk("rd5_b0", b0_rs_data, 64'h0000_0000_DEAD_BEEF);
    chk("rd5_busyvec", 64'(b1_busy_vec), 64'd0);

    // Writes to r0 are discarded
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
    set_rs(5'd0, 5'd0);
    settle();
    chk("wb0_same", b1_rs_data, 64'd0);
    tick();
    idle_main();
    settle();
    chk("rd0", b1_rs_data, 64'd0);
    chk("rd0_b0", b0_rs_data, 64'd0);

    // Make r7 busy, then forward its writeback on port 1
    iss_valid = 1'b1; iss_rd = 5'd7;
    settle();
    chk("iss7_ready", 64'(b1_ready), 64'd1);
    tick();
    idle_main();
    set_rs(5'd5, 5'd7);
    settle();
    chk("iss7_busyvec", 64'(b1_busy_vec), 64'h80);
    chk("iss7_rsbusy", 64'(b1_rs_busy), 64'b10);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5_A5A5;
    settle();
    chk("byp7_data", b1_rs_data, 64'hA5A5_A5A5_DEAD_BEEF);
    chk("byp7_busy", 64'(b1_rs_busy), 64'b00);
    chk("nobyp7_data", b0_rs_data, 64'h0000_0000_DEAD_BEEF);
    chk("nobyp7_busy", 64'(b0_rs_busy), 64'b10);
    tick();
    idle_main();
    settle();
    chk("wb7_b0_data", b0_rs_data, 64'hA5A5_A5A5_DEAD_BEEF);
    chk("wb7_busyvec", 64'(b1_busy_vec), 64'd0);

    // WAW stall on r3 released by a same-cycle writeback; issue wins on busy
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    settle();
    chk("iss3_busyvec", 64'(b1_busy_vec), 64'h8);
    chk("iss3_stall", 64'(b1_ready), 64'd0);
    chk("iss3_stall_b0", 64'(b0_ready), 64'd0);
    iss_valid = 1'b0;
    settle();
    chk("stall_no_valid", 64'(b1_ready), 64'd0);
    iss_rd = 5'd0;
    settle();
    chk("iss0_ready", 64'(b1_ready), 64'd1);
    iss_valid = 1'b1;
    tick();
    settle();
    chk("iss0_busyvec", 64'(b1_busy_vec), 64'h8);
    iss_rd = 5'd3;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
    settle();
    chk("waw_release", 64'(b1_ready), 64'd1);
    tick();
    idle_main();
    set_rs(5'd3, 5'd5);
    settle();
    chk("waw_busyvec", 64'(b1_busy_vec), 64'h8);
    chk("waw_data", b1_rs_data, 64'hDEAD_BEEF_0000_0033);
    chk("waw_rsbusy", 64'(b1_rs_busy), 64'b01);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0044;
    tick();
    idle_main();
    settle();
    chk("wb3_clear", 64'(b1_busy_vec), 64'd0);
    chk("wb3_data", b1_rs_data, 64'hDEAD_BEEF_0000_0044);

    // RV32E instance: three independent read ports
    e_wb_valid = 1'b1; e_wb_rd = 4'd1; e_wb_data = 32'h1111_1111;
    tick();
    e_wb_rd = 4'd15; e_wb_data = 32'hFFFF_000F;
    tick();
    e_wb_rd = 4'd0; e_wb_data = 32'h0000_0BAD;
    tick();
    e_wb_valid = 1'b0;
    e_rs_addr = {4'd0, 4'd15, 4'd1};
    settle();
    chk("e_rd_3port", e_rs_data[63:0], 64'hFFFF_000F_1111_1111);
    chk("e_rd_r0", 64'(e_rs_data[95:64]), 64'd0);

    // Mid-run reset with live state
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle_main();
    settle();
    chk("pre_rst_busy9", 64'(b1_busy_vec), 64'h200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mrst_busyvec", 64'(b1_busy_vec), 64'd0);
    chk("mrst_done", 64'(b1_done), 64'd0);
    chk("mrst_e_done", 64'(e_done), 64'd0);
    run_init("reinit");
    set_rs(5'd5, 5'd7);
    settle();
    chk("reinit_r5r7", b1_rs_data, 64'd0);
    set_rs(5'd3, 5'd9);
    settle();
    chk("reinit_r3r9", b1_rs_data, 64'd0);
    chk("reinit_r9busy", 64'(b1_rs_busy), 64'd0);
    e_rs_addr = {4'd0, 4'd15, 4'd1};
    settle();
    chk("reinit_e", e_rs_data[63:0], 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
